jtag_tap: RTL and testbench
===========================

Name: jtag_tap

Overview:
- Parametrised IEEE 1149.1 TAP: 16-state controller, IR of configurable width, BYPASS and IDCODE registers, TDO mux and N user data-register channels.
- Successor to the fixed 4-bit TAP controller; instruction decode and serial path are now built in.
- Sits between chip JTAG pins and on-chip user scan chains (debug, BIST, config).

Parameters:
- IR_WIDTH, 4, instruction register width; legal range 2..8.
- IDCODE_VAL, 32'h1000_0001, 32-bit device ID; bit 0 must be 1.
- IDCODE_OP, 1, IDCODE opcode.
- NUM_USER, 2, number of user DR channels; legal range 1..8.
- USER_BASE, 2, opcode of user channel 0; channel i uses USER_BASE+i.

Ports:
- TCK  in  1  test clock, the only clock; both edges used.
- TRST  in  1  asynchronous, active-high reset.
- TMS  in  1  mode select, sampled on posedge TCK.
- TDI  in  1  serial in, sampled on posedge TCK.
- TDO  out  1  serial out, changes on negedge TCK.
- TDO_EN  out  1  output enable for the TDO pad driver.
- STATE  out  4  current TAP state.
- IR_OUT  out  IR_WIDTH  active instruction.
- Resetn  out  1  low while in TEST_LOGIC_RESET; registered on negedge.
- USER_SEL  out  NUM_USER  one-hot selected user channel.
- USER_CAPTURE  out  1  selected user DR captures on the next posedge.
- USER_SHIFT  out  1  selected user DR shifts TDI on the next posedge.
- USER_UPDATE  out  1  high for the whole UPDATE_DR state.
- USER_TDO  in  NUM_USER  serial out of each user DR.

Behaviour:
- State encoding: EXIT2_DR=0, EXIT1_DR=1, SHIFT_DR=2, PAUSE_DR=3, SELECT_IR=4, UPDATE_DR=5, CAPTURE_DR=6, SELECT_DR=7, EXIT2_IR=8, EXIT1_IR=9, SHIFT_IR=A, PAUSE_IR=B, RTI=C, UPDATE_IR=D, CAPTURE_IR=E, TLR=F.
- Transitions per 1149.1; update on posedge TCK. Illegal codes go to TLR.
- TRST asserted asynchronously forces:
  - STATE=TLR, IR_OUT=IDCODE_OP, IR shifter=0, bypass=0, idcode shifter=IDCODE_VAL;
  - TDO=0, TDO_EN=0, Resetn=0.
- TRST mid-shift aborts the scan; IR_OUT is not altered by partial shift data.
- Five posedges with TMS=1 reach TLR from any state.
- IR path, all on posedge:
  - CAPTURE_IR loads the shifter with {0..0, 2'b01}.
  - SHIFT_IR: shifter <= {TDI, shifter[IR_WIDTH-1:1]}.
- IR_OUT updates on negedge TCK:
  - in UPDATE_IR, IR_OUT <= shifter;
  - in TLR, IR_OUT <= IDCODE_OP.
- Decode priority, highest first:
  - all-ones → BYPASS;
  - IDCODE_OP → IDCODE;
  - USER_BASE..USER_BASE+NUM_USER-1 → user channel;
  - anything else → BYPASS.
- Overlapping opcodes resolve by this priority.
- BYPASS register: CAPTURE_DR loads 0; SHIFT_DR loads TDI.
- IDCODE register: CAPTURE_DR loads IDCODE_VAL; SHIFT_DR shifts right with TDI entering at bit 31. LSB leaves first.
- User channels:
  - USER_SEL is a combinational decode of IR_OUT; all zeros when no user instruction is active.
  - USER_CAPTURE, USER_SHIFT and USER_UPDATE are combinational decodes of STATE (CAPTURE_DR, SHIFT_DR, UPDATE_DR), gated by |USER_SEL.
- TDO, updated on negedge TCK:
  - SHIFT_IR: TDO <= IR shifter[0].
  - SHIFT_DR: TDO <= bit 0 of the selected DR (bypass, idcode, or USER_TDO[i]).
  - Otherwise TDO holds.
  - TDO_EN <= (STATE==SHIFT_IR) or (STATE==SHIFT_DR).
- Net delay: one TCK cycle per DR bit plus a half-cycle output stage.

Optional Feature:
- Macro JTAG_TAP_USERCODE_EN.
- When defined:
  - adds parameters USERCODE_VAL (32'h0) and USERCODE_OP (IDCODE_OP+NUM_USER+1);
  - adds a 32-bit USERCODE register that behaves exactly like IDCODE, decoded just below IDCODE in priority.
- When undefined: that opcode decodes as BYPASS; no extra flops.

Test Plan:
- Pulse TRST, then TMS=0 into RTI, then scan DR for 32 bits → TDO yields 32'h1000_0001 LSB first; TDO_EN high only during SHIFT_DR.
- From each of the 16 states, 5 posedges with TMS=1 → STATE=F, Resetn=0 after the next negedge, IR_OUT=IDCODE_OP.
- IR scan with TDI=1111, IR_WIDTH=4 → first 4 TDO bits are 1,0,0,0 (captured 0001); IR_OUT=4'hF after UPDATE_IR negedge; a DR scan of 8 bits TDI=10110010 returns 0 then 1011001 (one-bit delay).
- Load IR=3 → USER_SEL=2'b10. DR scan: USER_CAPTURE high exactly in CAPTURE_DR, USER_SHIFT in SHIFT_DR, USER_UPDATE in UPDATE_DR. With USER_TDO[1] driven to 1, TDO=1.
- Mid-IR-shift after 2 bits, assert TRST asynchronously (between edges) → immediate STATE=F, TDO=0, TDO_EN=0, IR_OUT=IDCODE_OP.
- With JTAG_TAP_USERCODE_EN and USERCODE_VAL=32'hCAFE_F00D, load USERCODE_OP and scan 32 bits → TDO yields CAFEF00D. Without the macro, the same opcode gives a 1-bit bypass.

Source files
------------

// File: rtl/jtag_tap.sv
// jtag_tap: IEEE 1149.1 TAP with 16-state controller, IR, BYPASS, IDCODE and NUM_USER user DR channels.
// Optional 32-bit USERCODE register is enabled by defining JTAG_TAP_USERCODE_EN.
module jtag_tap #(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VAL   = 32'h1000_0001,
    parameter int          IDCODE_OP    = 1,
    parameter int          NUM_USER     = 2,
    parameter int          USER_BASE    = 2
`ifdef JTAG_TAP_USERCODE_EN
    ,
    parameter logic [31:0] USERCODE_VAL = 32'h0000_0000,
    parameter int          USERCODE_OP  = IDCODE_OP + NUM_USER + 1
`endif
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [3:0]          STATE,
    output logic [IR_WIDTH-1:0] IR_OUT,
    output logic                Resetn,
    output logic [NUM_USER-1:0] USER_SEL,
    output logic                USER_CAPTURE,
    output logic                USER_SHIFT,
    output logic                USER_UPDATE,
    input  logic [NUM_USER-1:0] USER_TDO
);

    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0, EXIT1_DR  = 4'h1, SHIFT_DR   = 4'h2, PAUSE_DR = 4'h3,
        SELECT_IR  = 4'h4, UPDATE_DR = 4'h5, CAPTURE_DR = 4'h6, SELECT_DR = 4'h7,
        EXIT2_IR   = 4'h8, EXIT1_IR  = 4'h9, SHIFT_IR   = 4'hA, PAUSE_IR = 4'hB,
        RTI        = 4'hC, UPDATE_IR = 4'hD, CAPTURE_IR = 4'hE, TLR      = 4'hF
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
    localparam logic [IR_WIDTH-1:0] IDCODE_IR  = IR_WIDTH'(IDCODE_OP);

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic                bypass_q, bypass_d;
    logic [31:0]         idcode_q, idcode_d;
    logic [IR_WIDTH-1:0] ir_out_q, ir_out_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, tdo_en_d;
    logic                resetn_q, resetn_d;
    logic [31:0]         ir_ext_s;
    logic                sel_idcode_s;
    logic [NUM_USER-1:0] user_sel_s;
    logic                dr_tdo_s;
`ifdef JTAG_TAP_USERCODE_EN
    logic [31:0]         usercode_q, usercode_d;
    logic                sel_usercode_s;
`endif

    // TAP controller next-state function
    always_comb begin
        state_d = TLR;
        case (state_q)
            TLR:        state_d = TMS ? TLR       : RTI;
            RTI:        state_d = TMS ? SELECT_DR : RTI;
            SELECT_DR:  state_d = TMS ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR: state_d = TMS ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:   state_d = TMS ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:   state_d = TMS ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   state_d = TMS ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:   state_d = TMS ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  state_d = TMS ? SELECT_DR : RTI;
            SELECT_IR:  state_d = TMS ? TLR       : CAPTURE_IR;
            CAPTURE_IR: state_d = TMS ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:   state_d = TMS ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:   state_d = TMS ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   state_d = TMS ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:   state_d = TMS ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  state_d = TMS ? SELECT_DR : RTI;
            default:    state_d = TLR;
        endcase
    end

    // Capture/shift behaviour of the IR shifter and the built-in data registers
    always_comb begin
        ir_shift_d = ir_shift_q;
        bypass_d   = bypass_q;
        idcode_d   = idcode_q;
`ifdef JTAG_TAP_USERCODE_EN
        usercode_d = usercode_q;
`endif
        if (state_q == CAPTURE_IR) begin
            ir_shift_d = IR_CAPTURE;
        end else if (state_q == SHIFT_IR) begin
            ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
        end else begin
            ir_shift_d = ir_shift_q;
        end
        if (state_q == CAPTURE_DR) begin
            bypass_d   = 1'b0;
            idcode_d   = IDCODE_VAL;
`ifdef JTAG_TAP_USERCODE_EN
            usercode_d = USERCODE_VAL;
`endif
        end else if (state_q == SHIFT_DR) begin
            bypass_d   = TDI;
            idcode_d   = {TDI, idcode_q[31:1]};
`ifdef JTAG_TAP_USERCODE_EN
            usercode_d = {TDI, usercode_q[31:1]};
`endif
        end else begin
            bypass_d   = bypass_q;
        end
    end

    // Rising-edge state: controller and all shift registers
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_q    <= TLR;
            ir_shift_q <= '0;
            bypass_q   <= 1'b0;
            idcode_q   <= IDCODE_VAL;
`ifdef JTAG_TAP_USERCODE_EN
            usercode_q <= USERCODE_VAL;
`endif
        end else begin
            state_q    <= state_d;
            ir_shift_q <= ir_shift_d;
            bypass_q   <= bypass_d;
            idcode_q   <= idcode_d;
`ifdef JTAG_TAP_USERCODE_EN
            usercode_q <= usercode_d;
`endif
        end
    end

    // Instruction decode; the if-chain order is the opcode priority
    always_comb begin
        ir_ext_s     = 32'(ir_out_q);
        sel_idcode_s = 1'b0;
        user_sel_s   = '0;
`ifdef JTAG_TAP_USERCODE_EN
        sel_usercode_s = 1'b0;
`endif
        if (ir_out_q == '1) begin
            sel_idcode_s = 1'b0;
        end else if (ir_ext_s == 32'(IDCODE_OP)) begin
            sel_idcode_s = 1'b1;
`ifdef JTAG_TAP_USERCODE_EN
        end else if (ir_ext_s == 32'(USERCODE_OP)) begin
            sel_usercode_s = 1'b1;
`endif
        end else begin
            for (int i = 0; i < NUM_USER; i++) begin
                user_sel_s[i] = (ir_ext_s == 32'(USER_BASE + i));
            end
        end
    end

    // Serial output of the currently selected data register
    always_comb begin
        dr_tdo_s = bypass_q;
        if (sel_idcode_s) begin
            dr_tdo_s = idcode_q[0];
`ifdef JTAG_TAP_USERCODE_EN
        end else if (sel_usercode_s) begin
            dr_tdo_s = usercode_q[0];
`endif
        end else if (|user_sel_s) begin
            dr_tdo_s = |(USER_TDO & user_sel_s);
        end else begin
            dr_tdo_s = bypass_q;
        end
    end

    // Falling-edge output stage: active instruction, TDO, TDO_EN, Resetn
    always_comb begin
        ir_out_d = ir_out_q;
        tdo_d    = tdo_q;
        if (state_q == UPDATE_IR) begin
            ir_out_d = ir_shift_q;
        end else if (state_q == TLR) begin
            ir_out_d = IDCODE_IR;
        end else begin
            ir_out_d = ir_out_q;
        end
        if (state_q == SHIFT_IR) begin
            tdo_d = ir_shift_q[0];
        end else if (state_q == SHIFT_DR) begin
            tdo_d = dr_tdo_s;
        end else begin
            tdo_d = tdo_q;
        end
        tdo_en_d = (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
        resetn_d = (state_q != TLR);
    end

    // Falling-edge registers so TDO is stable across the next rising edge
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_out_q <= IDCODE_IR;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
            resetn_q <= 1'b0;
        end else begin
            ir_out_q <= ir_out_d;
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
            resetn_q <= resetn_d;
        end
    end

    assign STATE        = state_q;
    assign IR_OUT       = ir_out_q;
    assign TDO          = tdo_q;
    assign TDO_EN       = tdo_en_q;
    assign Resetn       = resetn_q;
    assign USER_SEL     = user_sel_s;
    assign USER_CAPTURE = (state_q == CAPTURE_DR) && (|user_sel_s);
    assign USER_SHIFT   = (state_q == SHIFT_DR) && (|user_sel_s);
    assign USER_UPDATE  = (state_q == UPDATE_DR) && (|user_sel_s);

endmodule

// File: tb/tb_jtag_tap.sv
// tb_jtag_tap: randomized stimulus against a queue-based scan model of the TAP.
// Define JTAG_TAP_USERCODE_EN to check the USERCODE register.
module tb_jtag_tap;

    localparam int          IRW   = 4;
    localparam int          IDOP  = 1;
    localparam int          NU    = 2;
    localparam int          UBASE = 2;
    localparam logic [31:0] IDVAL = 32'h1000_0001;
    localparam int          UCOP  = IDOP + NU + 1;
    localparam logic [31:0] UCVAL = 32'hCAFE_F00D;

    logic           TCK = 1'b0;
    logic           TRST, TMS, TDI;
    logic           TDO, TDO_EN, Resetn, USER_CAPTURE, USER_SHIFT, USER_UPDATE;
    logic [3:0]     STATE;
    logic [IRW-1:0] IR_OUT;
    logic [NU-1:0]  USER_SEL, USER_TDO;
    logic [NU-1:0]  ut;

    int checks = 0;
    int errors = 0;

`ifdef JTAG_TAP_USERCODE_EN
    jtag_tap #(.IR_WIDTH(IRW), .IDCODE_VAL(IDVAL), .IDCODE_OP(IDOP), .NUM_USER(NU),
               .USER_BASE(UBASE), .USERCODE_VAL(UCVAL)) dut (
`else
    jtag_tap #(.IR_WIDTH(IRW), .IDCODE_VAL(IDVAL), .IDCODE_OP(IDOP), .NUM_USER(NU),
               .USER_BASE(UBASE)) dut (
`endif
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
        .STATE(STATE), .IR_OUT(IR_OUT), .Resetn(Resetn), .USER_SEL(USER_SEL),
        .USER_CAPTURE(USER_CAPTURE), .USER_SHIFT(USER_SHIFT), .USER_UPDATE(USER_UPDATE),
        .USER_TDO(USER_TDO)
    );

    always #5 TCK = ~TCK;

    // Next-state tables from the 1149.1 diagram, indexed by state code
    int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    int  m_state, m_ir;
    bit  irq[$];
    bit  drq[$];
    bit  m_tdo, m_en, m_resetn;
    bit  valid = 1'b0;

    // -1 bypass, -2 idcode, -3 usercode, >=0 user channel
    function automatic int dr_kind(input int ir);
        if (ir == (1 << IRW) - 1) return -1;
        if (ir == IDOP) return -2;
`ifdef JTAG_TAP_USERCODE_EN
        if (ir == UCOP) return -3;
`endif
        if (ir >= UBASE && ir < UBASE + NU) return ir - UBASE;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_state = 15; m_ir = IDOP; m_tdo = 1'b0; m_en = 1'b0; m_resetn = 1'b0;
        irq.delete(); drq.delete();
        for (int k = 0; k < IRW; k++) irq.push_back(1'b0);
    endtask

    always @(posedge TRST) m_reset();

    // Model: rising edge moves scan queues and the controller
    always @(posedge TCK) begin
        if (!TRST && valid) begin
            if (m_state == 14) begin
                irq.delete();
                irq.push_back(1'b1);
                for (int k = 1; k < IRW; k++) irq.push_back(1'b0);
            end else if (m_state == 10) begin
                void'(irq.pop_front());
                irq.push_back(TDI);
            end else if (m_state == 6) begin
                drq.delete();
                case (dr_kind(m_ir))
                    -1: drq.push_back(1'b0);
                    -2: for (int k = 0; k < 32; k++) drq.push_back(IDVAL[k]);
                    -3: for (int k = 0; k < 32; k++) drq.push_back(UCVAL[k]);
                    default: ;
                endcase
            end else if (m_state == 2) begin
                if (drq.size() > 0) void'(drq.pop_front());
                drq.push_back(TDI);
            end
            m_state = TMS ? nxt1[m_state] : nxt0[m_state];
        end
    end

    // Single compare process: falling-edge model update, then check every output
    always @(negedge TCK) begin
        if (!TRST && valid) begin
            int kind;
            int ir_val;
            logic [NU-1:0] sel;
            ir_val = 0;
            for (int k = 0; k < IRW; k++) ir_val += int'(irq[k]) << k;
            if (m_state == 13) m_ir = ir_val;
            else if (m_state == 15) m_ir = IDOP;
            kind = dr_kind(m_ir);
            if (m_state == 10) m_tdo = irq[0];
            else if (m_state == 2) m_tdo = (kind >= 0) ? USER_TDO[kind] : drq[0];
            m_en = (m_state == 10) || (m_state == 2);
            m_resetn = (m_state != 15);
            sel = (kind >= 0) ? NU'(1 << kind) : '0;
            #1;
            chk("state", 32'(STATE), 32'(m_state));
            chk("ir_out", 32'(IR_OUT), 32'(m_ir));
            chk("tdo", 32'(TDO), 32'(m_tdo));
            chk("tdo_en", 32'(TDO_EN), 32'(m_en));
            chk("resetn", 32'(Resetn), 32'(m_resetn));
            chk("user_sel", 32'(USER_SEL), 32'(sel));
            chk("user_capture", 32'(USER_CAPTURE), 32'((m_state == 6) && (kind >= 0)));
            chk("user_shift", 32'(USER_SHIFT), 32'((m_state == 2) && (kind >= 0)));
            chk("user_update", 32'(USER_UPDATE), 32'((m_state == 5) && (kind >= 0)));
        end
    end

    task automatic tick(input bit tms, input bit tdi);
        TMS = tms; TDI = tdi; USER_TDO = ut;
        @(posedge TCK);
        @(negedge TCK);
        #2;
    endtask

    task automatic pulse_trst();
        TRST = 1'b1;
        #1;
        chk("trst_state", 32'(STATE), 32'hF);
        chk("trst_tdo", 32'(TDO), 32'h0);
        chk("trst_tdo_en", 32'(TDO_EN), 32'h0);
        chk("trst_ir_out", 32'(IR_OUT), 32'(IDOP));
        chk("trst_resetn", 32'(Resetn), 32'h0);
        TRST = 1'b0;
        TMS = 1'b1;
        @(negedge TCK);
        #2;
    endtask

    // Both scans start and end in RTI
    task automatic scan_dr(input int n, input logic [31:0] tdi, output logic [31:0] got);
        got = '0;
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int k = 0; k < n; k++) begin
            got[k] = TDO;
            tick(k == n - 1, tdi[k]);
        end
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    endtask

    task automatic scan_ir(input logic [IRW-1:0] val, output logic [IRW-1:0] got);
        got = '0;
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int k = 0; k < IRW; k++) begin
            got[k] = TDO;
            tick(k == IRW - 1, val[k]);
        end
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0]    got;
        logic [IRW-1:0] irgot;
        int             steps;
        TRST = 1'b0; TMS = 1'b1; TDI = 1'b0; ut = '0; USER_TDO = '0;
        #1 TRST = 1'b1;
        @(negedge TCK);
        #2;
        chk("rst_state", 32'(STATE), 32'hF);
        chk("rst_ir_out", 32'(IR_OUT), 32'(IDOP));
        chk("rst_tdo_en", 32'(TDO_EN), 32'h0);
        chk("rst_resetn", 32'(Resetn), 32'h0);
        TRST = 1'b0;
        valid = 1'b1;
        tick(1'b0, 1'b0);
        chk("rti_resetn", 32'(Resetn), 32'h1);

        scan_dr(32, 32'h0, got);
        chk("idcode_scan", got, 32'h1000_0001);

        scan_ir(4'hF, irgot);
        chk("ir_capture", 32'(irgot), 32'h1);
        chk("ir_all_ones", 32'(IR_OUT), 32'hF);
        scan_dr(8, 32'h4D, got);
        chk("bypass_scan", got, 32'h9A);

        scan_ir(4'h3, irgot);
        chk("user_sel_ch1", 32'(USER_SEL), 32'h2);
        ut = 2'b10;
        scan_dr(8, 32'h0, got);
        chk("user_tdo_ch1", got, 32'hFF);
        ut = 2'b01;
        scan_dr(4, 32'h0, got);
        chk("user_tdo_ch1_low", got, 32'h0);
        ut = 2'b00;

        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b1); tick(1'b0, 1'b1);
        chk("pre_trst_shift_ir", 32'(STATE), 32'hA);
        pulse_trst();
        tick(1'b0, 1'b0);

        scan_ir(IRW'(UCOP), irgot);
        scan_dr(32, 32'hFFFF_FFFF, got);
`ifdef JTAG_TAP_USERCODE_EN
        chk("usercode_scan", got, 32'hCAFE_F00D);
`else
        chk("usercode_as_bypass", got, 32'hFFFF_FFFE);
`endif

        for (int t = 0; t < 16; t++) begin
            steps = 0;
            while (32'(STATE) != t && steps < 2000) begin
                ut = NU'($urandom);
                tick(1'($urandom), 1'($urandom));
                steps++;
            end
            chk("reach_state", 32'(STATE), t);
            repeat (5) tick(1'b1, 1'b0);
            chk("tlr_state", 32'(STATE), 32'hF);
            chk("tlr_resetn", 32'(Resetn), 32'h0);
            chk("tlr_ir_out", 32'(IR_OUT), 32'(IDOP));
        end

        for (int i = 0; i < 3000; i++) begin
            ut = NU'($urandom);
            if (i % 400 == 399) pulse_trst();
            else tick($urandom_range(0, 3) == 0, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
